// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared sizes and FSM state encoding for the instruction memory loader
package imem_loader_pkg;

   localparam int IMEM_DEPTH = 32;
   localparam int IMEM_AW    = 8;
   localparam int IMEM_DW    = 8;

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      DATA,
      CSUM,
      ERR
   } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - valid/ready byte stream carrying the framed program image
interface imem_loader_if #(
   parameter int DW = 8
) ();

   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready
   );

endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream writer for the instruction RAM, holds the CPU while loading
// Optional checksum byte and compare enabled by defining IMEM_LOADER_CSUM_EN.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH = IMEM_DEPTH,
   parameter int AW    = IMEM_AW,
   parameter int DW    = IMEM_DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_req,
   imem_loader_if.slave  in_bus,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          cpu_hold,
   output logic          done,
   output logic          err
);

   localparam logic [AW-1:0] ONE     = AW'(1);
   localparam logic [DW:0]   MAX_LEN = (DW+1)'(DEPTH);

   state_t        state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [AW-1:0] len_q, len_d;
`ifdef IMEM_LOADER_CSUM_EN
   logic [DW-1:0] sum_q, sum_d;
`endif

   logic          mem_we_d;
   logic [AW-1:0] mem_addr_d;
   logic [DW-1:0] mem_wdata_d;
   logic          done_d;

   logic          busy;
   logic          accept;
   logic          len_bad;
   logic          last_byte;

   assign busy            = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
   assign in_bus.in_ready = busy && !load_req;
   assign accept          = in_bus.in_valid && in_bus.in_ready;
   assign len_bad         = (in_bus.in_data == '0) || ({1'b0, in_bus.in_data} > MAX_LEN);
   assign last_byte       = (idx_q == len_q - ONE);
   assign cpu_hold        = (state_q != IDLE);
   assign err             = (state_q == ERR);

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      len_d       = len_q;
`ifdef IMEM_LOADER_CSUM_EN
      sum_d       = sum_q;
`endif
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      done_d      = 1'b0;

      // A load request restarts from any state and wins over a coincident byte.
      if (load_req) begin
         state_d = LEN;
         idx_d   = '0;
`ifdef IMEM_LOADER_CSUM_EN
         sum_d   = '0;
`endif
      end else if (accept) begin
         case (state_q)
            LEN: begin
               if (len_bad) begin
                  state_d = ERR;
               end else begin
                  len_d   = AW'(in_bus.in_data);
                  state_d = DATA;
               end
            end
            DATA: begin
               mem_we_d    = 1'b1;
               mem_addr_d  = idx_q;
               mem_wdata_d = in_bus.in_data;
               idx_d       = idx_q + ONE;
`ifdef IMEM_LOADER_CSUM_EN
               sum_d       = sum_q + in_bus.in_data;
               if (last_byte) begin
                  state_d = CSUM;
               end
`else
               if (last_byte) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
`endif
            end
`ifdef IMEM_LOADER_CSUM_EN
            CSUM: begin
               if (in_bus.in_data == sum_q) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ERR;
               end
            end
`endif
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         len_q     <= '0;
`ifdef IMEM_LOADER_CSUM_EN
         sum_q     <= '0;
`endif
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         len_q     <= len_d;
`ifdef IMEM_LOADER_CSUM_EN
         sum_q     <= sum_d;
`endif
         mem_we    <= mem_we_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
         done      <= done_d;
      end
   end

endmodule
